// File: rtl/uart_byte_fifo.sv
// Byte FIFO between UART receiver and transmitter: first-word fall-through, sticky overflow.
// Define UART_FIFO_STATS_EN to build the drop counter and high-water mark; otherwise both read 0.
module uart_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     wr_valid,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic [15:0]              drop_count,
  output logic [$clog2(DEPTH):0]   peak_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             overflow_q, overflow_d;
  logic             push, pop, drop;

  assign empty    = (level_q == '0);
  assign full     = (level_q == FULL_LEVEL);
  assign rd_valid = ~empty;
  assign rd_data  = mem_q[rd_ptr_q];
  assign level    = level_q;
  assign overflow = overflow_q;

  // A pop frees the slot on the same edge, so a full FIFO still accepts a push then.
  always_comb begin
    pop        = rd_valid & rd_ready & ~clear;
    push       = wr_valid & (~full | rd_ready) & ~clear;
    drop       = wr_valid & full & ~rd_ready & ~clear;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q | drop;
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage has no reset; contents are only observable while rd_valid is high.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

`ifdef UART_FIFO_STATS_EN
  logic [15:0]   drop_count_q, drop_count_d;
  logic [LW-1:0] peak_level_q, peak_level_d;

  always_comb begin
    drop_count_d = drop_count_q;
    peak_level_d = peak_level_q;
    if (clear) begin
      drop_count_d = '0;
      peak_level_d = '0;
    end else begin
      if (drop && (drop_count_q != 16'hFFFF)) drop_count_d = drop_count_q + 16'd1;
      if (level_d > peak_level_q)             peak_level_d = level_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count_q <= '0;
      peak_level_q <= '0;
    end else begin
      drop_count_q <= drop_count_d;
      peak_level_q <= peak_level_d;
    end
  end

  assign drop_count = drop_count_q;
  assign peak_level = peak_level_q;
`else
  assign drop_count = '0;
  assign peak_level = '0;
`endif

endmodule

// File: tb/tb_uart_byte_fifo.sv
// Directed self-checking bench for uart_byte_fifo (DEPTH=16, WIDTH=8).
// Statistics expectations follow UART_FIFO_STATS_EN when it is defined.
module tb_uart_byte_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [4:0] level;
  logic       full;
  logic       empty;
  logic       overflow;
  logic [15:0] drop_count;
  logic [4:0] peak_level;

  int checks = 0;
  int failures = 0;

  uart_byte_fifo #(.DEPTH(16), .WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .wr_data(wr_data), .wr_valid(wr_valid),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .level(level), .full(full), .empty(empty), .overflow(overflow),
    .drop_count(drop_count), .peak_level(peak_level)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_data  = base + 8'(i);
      tick();
    end
    wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; wr_valid = 1'b0; wr_data = 8'h00; rd_ready = 1'b0;
    #2;
    checks++; if (level !== 5'd0)  begin failures++; $display("[TB] FAIL reset_level got=%0d exp=0", level); end
    checks++; if (empty !== 1'b1)  begin failures++; $display("[TB] FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0)   begin failures++; $display("[TB] FAIL reset_full got=%b exp=0", full); end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if (drop_count !== 16'd0) begin failures++; $display("[TB] FAIL reset_drop_count got=%0d exp=0", drop_count); end
    checks++; if (peak_level !== 5'd0) begin failures++; $display("[TB] FAIL reset_peak got=%0d exp=0", peak_level); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    fill(8'h41, 3);
    checks++; if (level !== 5'd3) begin failures++; $display("[TB] FAIL basic_level got=%0d exp=3", level); end
    checks++; if (rd_data !== 8'h41 || rd_valid !== 1'b1)
      begin failures++; $display("[TB] FAIL basic_head got=%h/%b exp=41/1", rd_data, rd_valid); end
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 8'h41 + 8'(i))
        begin failures++; $display("[TB] FAIL basic_pop%0d got=%h/%b exp=%h/1", i, rd_data, rd_valid, 8'h41 + 8'(i)); end
      tick();
    end
    rd_ready = 1'b0;
    checks++; if (empty !== 1'b1 || rd_valid !== 1'b0)
      begin failures++; $display("[TB] FAIL basic_empty got=%b/%b exp=1/0", empty, rd_valid); end
  endtask

  task automatic test_overflow();
    fill(8'h00, 16);
    checks++; if (full !== 1'b1 || level !== 5'd16 || overflow !== 1'b0)
      begin failures++; $display("[TB] FAIL ovf_fill got full=%b level=%0d ovf=%b exp 1/16/0", full, level, overflow); end
    wr_valid = 1'b1; wr_data = 8'hAA;
    tick();
    wr_valid = 1'b0;
    checks++; if (full !== 1'b1 || level !== 5'd16 || overflow !== 1'b1)
      begin failures++; $display("[TB] FAIL ovf_drop got full=%b level=%0d ovf=%b exp 1/16/1", full, level, overflow); end
`ifdef UART_FIFO_STATS_EN
    checks++; if (drop_count !== 16'd1) begin failures++; $display("[TB] FAIL ovf_drop_count got=%0d exp=1", drop_count); end
    checks++; if (peak_level !== 5'd16) begin failures++; $display("[TB] FAIL ovf_peak got=%0d exp=16", peak_level); end
`else
    checks++; if (drop_count !== 16'd0) begin failures++; $display("[TB] FAIL ovf_drop_count got=%0d exp=0", drop_count); end
    checks++; if (peak_level !== 5'd0) begin failures++; $display("[TB] FAIL ovf_peak got=%0d exp=0", peak_level); end
`endif
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 8'(i))
        begin failures++; $display("[TB] FAIL ovf_drain%0d got=%h/%b exp=%h/1", i, rd_data, rd_valid, 8'(i)); end
      tick();
    end
    rd_ready = 1'b0;
    checks++; if (empty !== 1'b1 || overflow !== 1'b1)
      begin failures++; $display("[TB] FAIL ovf_after_drain got empty=%b ovf=%b exp 1/1", empty, overflow); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (overflow !== 1'b0 || drop_count !== 16'd0 || peak_level !== 5'd0)
      begin failures++; $display("[TB] FAIL ovf_clear got ovf=%b drops=%0d peak=%0d exp 0/0/0", overflow, drop_count, peak_level); end
  endtask

  task automatic test_full_push_pop();
    fill(8'h10, 16);
    wr_valid = 1'b1; wr_data = 8'h55; rd_ready = 1'b1;
    tick();
    wr_valid = 1'b0; rd_ready = 1'b0;
    checks++; if (level !== 5'd16 || overflow !== 1'b0 || full !== 1'b1)
      begin failures++; $display("[TB] FAIL fullpp_state got level=%0d ovf=%b full=%b exp 16/0/1", level, overflow, full); end
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] exp_b;
      exp_b = (i == 15) ? 8'h55 : 8'h11 + 8'(i);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_b)
        begin failures++; $display("[TB] FAIL fullpp_drain%0d got=%h/%b exp=%h/1", i, rd_data, rd_valid, exp_b); end
      tick();
    end
    rd_ready = 1'b0;
    checks++; if (empty !== 1'b1) begin failures++; $display("[TB] FAIL fullpp_empty got=%b exp=1", empty); end
  endtask

  task automatic test_empty_push_pop();
    wr_valid = 1'b1; wr_data = 8'h7E; rd_ready = 1'b1;
    tick();
    wr_valid = 1'b0; rd_ready = 1'b0;
    checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h7E || level !== 5'd1)
      begin failures++; $display("[TB] FAIL emptypp got=%h/%b level=%0d exp=7e/1 level=1", rd_data, rd_valid, level); end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    checks++; if (empty !== 1'b1) begin failures++; $display("[TB] FAIL emptypp_drain got=%b exp=1", empty); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_q [20];
    int pop_idx = 0;
    int remaining;
    for (int k = 0; k < 20; k++) exp_q[k] = 8'h80 + 8'(k);
    for (int k = 0; k < 20; k++) begin
      wr_valid = 1'b1;
      wr_data  = exp_q[k];
      rd_ready = (k % 2) == 1;
      if (rd_ready && rd_valid) begin
        checks++;
        if (rd_data !== exp_q[pop_idx])
          begin failures++; $display("[TB] FAIL wrap_pop%0d got=%h exp=%h", pop_idx, rd_data, exp_q[pop_idx]); end
        pop_idx++;
      end
      tick();
    end
    wr_valid = 1'b0; rd_ready = 1'b0;
    checks++; if (level !== 5'd10 || overflow !== 1'b0 || pop_idx != 10)
      begin failures++; $display("[TB] FAIL wrap_mid got level=%0d ovf=%b pops=%0d exp 10/0/10", level, overflow, pop_idx); end
    remaining = 20 - pop_idx;
    rd_ready = 1'b1;
    for (int j = 0; j < remaining; j++) begin
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_q[pop_idx])
        begin failures++; $display("[TB] FAIL wrap_drain%0d got=%h/%b exp=%h/1", pop_idx, rd_data, rd_valid, exp_q[pop_idx]); end
      pop_idx++;
      tick();
    end
    rd_ready = 1'b0;
    checks++; if (empty !== 1'b1 || overflow !== 1'b0)
      begin failures++; $display("[TB] FAIL wrap_end got empty=%b ovf=%b exp 1/0", empty, overflow); end
  endtask

  task automatic test_async_reset();
    fill(8'h30, 16);
    wr_valid = 1'b1; wr_data = 8'hEE;
    tick();
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    repeat (11) tick();
    rd_ready = 1'b0;
    checks++; if (level !== 5'd5 || overflow !== 1'b1)
      begin failures++; $display("[TB] FAIL arst_pre got level=%0d ovf=%b exp 5/1", level, overflow); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (level !== 5'd0 || empty !== 1'b1 || rd_valid !== 1'b0 || overflow !== 1'b0)
      begin failures++; $display("[TB] FAIL arst got level=%0d empty=%b rd_valid=%b ovf=%b exp 0/1/0/0", level, empty, rd_valid, overflow); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_clear();
    fill(8'h60, 7);
    checks++; if (level !== 5'd7) begin failures++; $display("[TB] FAIL clear_pre got=%0d exp=7", level); end
    clear = 1'b1; wr_valid = 1'b1; wr_data = 8'h99;
    tick();
    clear = 1'b0; wr_valid = 1'b0;
    checks++; if (level !== 5'd0 || empty !== 1'b1 || rd_valid !== 1'b0)
      begin failures++; $display("[TB] FAIL clear got level=%0d empty=%b rd_valid=%b exp 0/1/0", level, empty, rd_valid); end
    fill(8'h5A, 1);
    checks++; if (level !== 5'd1 || rd_data !== 8'h5A)
      begin failures++; $display("[TB] FAIL clear_after got level=%0d data=%h exp 1/5a", level, rd_data); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_empty_push_pop();
    test_wrap();
    test_async_reset();
    test_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_byte_fifo.md
# uart_byte_fifo

Synchronous byte FIFO between the UART receiver and the UART transmitter: it absorbs `rx_valid`/`rx_data` strobes and presents them to the transmitter through a valid/ready handshake, so that back-to-back received bytes are not lost while the transmitter is busy. It also provides an occupancy level, full/empty flags and a sticky overflow flag for the HEX display and the status LEDs.

## Interface
- `DEPTH`, 16, number of entries; power of two, ≥ 2
- `WIDTH`, 8, data width in bits
- `clk`  in  1  system clock (50 MHz)
- `rst_n`  in  1  asynchronous, active-low reset
- `clear`  in  1  synchronous flush; single-cycle pulse
- `wr_data`  in  WIDTH  byte to push (from the receiver's `data_out`)
- `wr_valid`  in  1  push strobe (from the receiver's `data_valid`); no backpressure
- `rd_data`  out  WIDTH  head-of-queue byte; valid only while `rd_valid`=1
- `rd_valid`  out  1  queue non-empty (drives the transmitter's `tx_valid`)
- `rd_ready`  in  1  consumer accepts the head (the transmitter's `tx_ready`)
- `level`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- `full`  out  1  `level`==DEPTH
- `empty`  out  1  `level`==0
- `overflow`  out  1  sticky: a byte was dropped
- `drop_count`  out  16  dropped-byte count (see Configuration)
- `peak_level`  out  $clog2(DEPTH)+1  high-water mark (see Configuration)

## Operation
- Storage: a DEPTH×WIDTH register array, a write pointer and a read pointer, each $clog2(DEPTH) bits wide and wrapping modulo DEPTH. Occupancy is held in a separate `level` counter.
- `rd_data` = `mem[rd_ptr]` (first-word fall-through); `rd_valid` = `~empty`.
- Push: accepted on a rising edge when `wr_valid`=1 and (`full`=0, or a pop occurs on the same edge). It writes `mem[wr_ptr]` and increments `wr_ptr`.
- Pop: occurs on a rising edge when `rd_valid`=1 and `rd_ready`=1. It increments `rd_ptr`.
- Level update: push only → +1; pop only → −1; push and pop together → unchanged.
- Full with push and pop on the same edge: the push is accepted and `level` stays DEPTH.
- Empty with `wr_valid`=1 and `rd_ready`=1: no pop occurs, because `rd_valid` was 0. `level` becomes 1.
- Overflow: `wr_valid`=1 while `full`=1 with no pop on that edge. The byte is discarded, and the pointers and `level` are unchanged. `overflow` is set and held until `clear` or reset.
- `clear`=1: on that edge, pointers ← 0, `level` ← 0 and `overflow` ← 0. A same-cycle push or pop is ignored. Stored data is not zeroed.
- Reset (`rst_n`=0, any time, including mid-transfer): pointers 0, `level` 0, `empty` 1, `full` 0, `rd_valid` 0, `overflow` 0, `drop_count` 0, `peak_level` 0. Memory contents are don't-care; `rd_data` is undefined while `rd_valid`=0.

## Timing
- Write-to-read latency: a byte pushed at edge N is visible on `rd_data` with `rd_valid`=1 after edge N. This is 1 cycle when the FIFO was empty.
- Pop takes effect at the edge. The next entry, or `rd_valid`=0, appears after that edge, so the consumer may pop every cycle.
- `level`, `full`, `empty`, `overflow`, `drop_count` and `peak_level` are all registered or derived from registers, and update after the causing edge.
- No combinational path from `rd_ready` or `wr_valid` to any output.
- Sustained throughput: one push and one pop per cycle.

## Configuration
- Macro `UART_FIFO_STATS_EN`.
- Defined:
  - `drop_count` increments on every discarded byte and saturates at 16'hFFFF.
  - `peak_level` ← max(`peak_level`, next `level`) each cycle.
  - Both are cleared by reset and by `clear`.
- Undefined: `drop_count` and `peak_level` are tied to 0 and no counter logic is built. Ports are present in both builds so the top level is unchanged.

## Test plan
- Reset, then push 0x41, 0x42, 0x43 with `rd_ready`=0 → `level`=3 and `rd_data`=0x41. Then hold `rd_ready`=1 → pops 0x41, 0x42, 0x43 on consecutive edges, then `empty`=1.
- Push 16 bytes 0x00..0x0F, then push 0xAA with `rd_ready`=0 → `full`=1, `overflow`=1 and `level`=16. Drain returns 0x00..0x0F in order, and 0xAA is never seen. With `UART_FIFO_STATS_EN`: `drop_count`=1 and `peak_level`=16.
- When full, push 0x55 and pop on the same edge → `level` stays 16, `overflow` stays 0, and 0x55 is the last byte drained.
- When empty, `wr_valid`=1 with 0x7E and `rd_ready`=1 → no pop. The next cycle shows `rd_valid`=1, `rd_data`=0x7E and `level`=1.
- Push 20 bytes while popping every other cycle, so the pointers wrap past 15 → output order equals input order, with no drops.
- Assert `rst_n`=0 asynchronously (mid-clock) with `level`=5 and `overflow`=1 → immediately `level`=0, `empty`=1, `rd_valid`=0 and `overflow`=0. Also pulse `clear` with `level`=7 and a same-cycle push → `level`=0 after the edge.
